// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, sequencer states and control strobe bundle
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  typedef struct packed {
    logic PCout;
    logic MDRout;
    logic Zlowout;
    logic Zhighout;
    logic HIout;
    logic LOout;
    logic InPortout;
    logic Csignout;
    logic PCin;
    logic IRin;
    logic MARin;
    logic MDRin;
    logic Yin;
    logic Zlowin;
    logic Zhighin;
    logic HIin;
    logic LOin;
    logic Out_Portin;
    logic CONin;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
    logic BAout;
    logic Read;
    logic Write;
    logic MD_read;
    logic IncPC;
    logic ADD;
    logic AND;
    logic OR;
    logic BRANCH;
  } ctl_t;

  // Final step of each instruction; anything unrecognised ends after fetch.
  function automatic state_t last_step(input logic [4:0] op);
    case (op)
      OP_ADD, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_step = T5;
      OP_LD:                                                  last_step = T7;
      OP_ST, OP_BR:                                           last_step = T6;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:                 last_step = T3;
      default:                                                last_step = T2;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational map of (state, opcode, CONFF) to datapath strobes
module control_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] op,
  input  logic       CONFF,
  output ctl_t       ctl
);

  logic alu_reg, alu_imm, mem_op;

  assign alu_reg = (op == OP_ADD) || (op == OP_AND) || (op == OP_OR);
  assign alu_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign mem_op  = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);

  always_comb begin
    ctl = '0;
    case (state)
      T0: begin
        ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.IncPC = 1'b1; ctl.Zlowin = 1'b1;
      end
      T1: begin
        ctl.Zlowout = 1'b1; ctl.PCin = 1'b1; ctl.Read = 1'b1;
        ctl.MD_read = 1'b1; ctl.MDRin = 1'b1;
      end
      T2: begin
        ctl.MDRout = 1'b1; ctl.IRin = 1'b1;
      end
      T3: begin
        if (alu_reg || alu_imm) begin
          ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1;
        end else if (mem_op) begin
          ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.Yin = 1'b1;
        end else begin
          case (op)
            OP_BR:   begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.CONin = 1'b1; end
            OP_JR:   begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
            OP_IN:   begin ctl.InPortout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            OP_OUT:  begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.Out_Portin = 1'b1; end
            OP_MFHI: begin ctl.HIout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            OP_MFLO: begin ctl.LOout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      T4: begin
        if (alu_reg || alu_imm) begin
          ctl.Grc      = alu_reg;
          ctl.Rout     = alu_reg;
          ctl.Csignout = alu_imm;
          ctl.ADD      = (op == OP_ADD) || (op == OP_ADDI);
          ctl.AND      = (op == OP_AND) || (op == OP_ANDI);
          ctl.OR       = (op == OP_OR)  || (op == OP_ORI);
          ctl.Zlowin   = 1'b1;
        end else if (mem_op) begin
          ctl.Csignout = 1'b1; ctl.ADD = 1'b1; ctl.Zlowin = 1'b1;
        end else if (op == OP_BR) begin
          ctl.PCout = 1'b1; ctl.Yin = 1'b1;
        end
      end
      T5: begin
        if (alu_reg || alu_imm || op == OP_LDI) begin
          ctl.Zlowout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
        end else if (op == OP_LD || op == OP_ST) begin
          ctl.Zlowout = 1'b1; ctl.MARin = 1'b1;
        end else if (op == OP_BR) begin
          ctl.Csignout = 1'b1; ctl.ADD = 1'b1; ctl.BRANCH = 1'b1; ctl.Zlowin = 1'b1;
        end
      end
      T6: begin
        case (op)
          OP_LD: begin ctl.Read = 1'b1; ctl.MD_read = 1'b1; ctl.MDRin = 1'b1; end
          OP_ST: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.Write = 1'b1; end
          // Branch target is already in Z; the condition decides whether PC takes it.
          OP_BR: begin ctl.Zlowout = 1'b1; ctl.PCin = CONFF; end
          default: ;
        endcase
      end
      T7: begin
        if (op == OP_LD) begin
          ctl.MDRout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired CPU sequencer: state register, step logic, retire counter
module control_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             CONFF,
  input  logic             stop,
  output logic             run,
  output logic [CNT_W-1:0] instr_count,
  output logic             PCout,
  output logic             MDRout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIout,
  output logic             LOout,
  output logic             InPortout,
  output logic             Csignout,
  output logic             PCin,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             HIin,
  output logic             LOin,
  output logic             Out_Portin,
  output logic             CONin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Read,
  output logic             Write,
  output logic             MD_read,
  output logic             IncPC,
  output logic             ADD,
  output logic             AND,
  output logic             OR,
  output logic             BRANCH
);

  state_t     state, state_nxt;
  logic       rst_done;
  logic       retire;
  logic [4:0] op;
  logic       unused_ir;
  ctl_t       ctl;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // rst_done holds RESET_S for one full cycle after clear is released.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= RESET_S;
      rst_done    <= 1'b0;
      instr_count <= '0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      RESET_S: if (rst_done) state_nxt = T0;
      HALT:    state_nxt = HALT;
      default: begin
        if (state == last_step(op)) begin
          retire    = 1'b1;
          state_nxt = (stop || op == OP_HALT) ? HALT : T0;
        end else begin
          state_nxt = state_t'(state + 4'd1);
        end
      end
    endcase
  end

  assign run = (state != RESET_S) && (state != HALT);

  control_decode u_decode (
    .state (state),
    .op    (op),
    .CONFF (CONFF),
    .ctl   (ctl)
  );

  assign PCout      = ctl.PCout;
  assign MDRout     = ctl.MDRout;
  assign Zlowout    = ctl.Zlowout;
  assign Zhighout   = ctl.Zhighout;
  assign HIout      = ctl.HIout;
  assign LOout      = ctl.LOout;
  assign InPortout  = ctl.InPortout;
  assign Csignout   = ctl.Csignout;
  assign PCin       = ctl.PCin;
  assign IRin       = ctl.IRin;
  assign MARin      = ctl.MARin;
  assign MDRin      = ctl.MDRin;
  assign Yin        = ctl.Yin;
  assign Zlowin     = ctl.Zlowin;
  assign Zhighin    = ctl.Zhighin;
  assign HIin       = ctl.HIin;
  assign LOin       = ctl.LOin;
  assign Out_Portin = ctl.Out_Portin;
  assign CONin      = ctl.CONin;
  assign Gra        = ctl.Gra;
  assign Grb        = ctl.Grb;
  assign Grc        = ctl.Grc;
  assign Rin        = ctl.Rin;
  assign Rout       = ctl.Rout;
  assign BAout      = ctl.BAout;
  assign Read       = ctl.Read;
  assign Write      = ctl.Write;
  assign MD_read    = ctl.MD_read;
  assign IncPC      = ctl.IncPC;
  assign ADD        = ctl.ADD;
  assign AND        = ctl.AND;
  assign OR         = ctl.OR;
  assign BRANCH     = ctl.BRANCH;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized instruction streams against a step-table reference model
module tb_control_unit;
  import cpu_pkg::*;

  localparam int CW = 4;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic [31:0] IR = '0;
  logic CONFF = 1'b0;
  logic stop = 1'b0;
  logic run;
  logic [CW-1:0] instr_count;
  logic PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Csignout;
  logic PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, Out_Portin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic Read, Write, MD_read, IncPC, ADD, AND, OR, BRANCH;

  logic [32:0] obs;
  int n_checks = 0;
  int n_err = 0;
  int unsigned mcount = 0;

  always #5 clock = ~clock;

  control_unit #(.CNT_W(CW)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CONFF(CONFF), .stop(stop),
    .run(run), .instr_count(instr_count),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Csignout(Csignout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
    .Out_Portin(Out_Portin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .Write(Write), .MD_read(MD_read), .IncPC(IncPC),
    .ADD(ADD), .AND(AND), .OR(OR), .BRANCH(BRANCH)
  );

  assign obs = {PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Csignout,
                PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, Out_Portin, CONin,
                Gra, Grb, Grc, Rin, Rout, BAout,
                Read, Write, MD_read, IncPC, ADD, AND, OR, BRANCH};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_lat(input logic [4:0] op);
    case (op)
      OP_ADD, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return 6;
      OP_LD: return 8;
      OP_ST, OP_BR: return 7;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return 4;
      default: return 3;
    endcase
  endfunction

  // Expected strobes for step k (0 = T0) of one instruction, straight from the step tables.
  function automatic logic [32:0] ref_step(input logic [4:0] op, input int k, input logic cf);
    ctl_t c;
    bit r3, ri, ldx;
    c = '0;
    r3  = (op == OP_ADD) || (op == OP_AND) || (op == OP_OR);
    ri  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    ldx = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    if (k == 0) begin c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zlowin = 1; end
    else if (k == 1) begin c.Zlowout = 1; c.PCin = 1; c.Read = 1; c.MD_read = 1; c.MDRin = 1; end
    else if (k == 2) begin c.MDRout = 1; c.IRin = 1; end
    else if (r3 || ri) begin
      if (k == 3) begin c.Grb = 1; c.Rout = 1; c.Yin = 1; end
      if (k == 4) begin
        if (r3) begin c.Grc = 1; c.Rout = 1; end else c.Csignout = 1;
        c.ADD = (op == OP_ADD || op == OP_ADDI);
        c.AND = (op == OP_AND || op == OP_ANDI);
        c.OR  = (op == OP_OR  || op == OP_ORI);
        c.Zlowin = 1;
      end
      if (k == 5) begin c.Zlowout = 1; c.Gra = 1; c.Rin = 1; end
    end else if (ldx) begin
      if (k == 3) begin c.Grb = 1; c.BAout = 1; c.Yin = 1; end
      if (k == 4) begin c.Csignout = 1; c.ADD = 1; c.Zlowin = 1; end
      if (k == 5 && op == OP_LDI) begin c.Zlowout = 1; c.Gra = 1; c.Rin = 1; end
      if (k == 5 && op != OP_LDI) begin c.Zlowout = 1; c.MARin = 1; end
      if (k == 6 && op == OP_LD) begin c.Read = 1; c.MD_read = 1; c.MDRin = 1; end
      if (k == 6 && op == OP_ST) begin c.Gra = 1; c.Rout = 1; c.Write = 1; end
      if (k == 7) begin c.MDRout = 1; c.Gra = 1; c.Rin = 1; end
    end else if (op == OP_BR) begin
      if (k == 3) begin c.Gra = 1; c.Rout = 1; c.CONin = 1; end
      if (k == 4) begin c.PCout = 1; c.Yin = 1; end
      if (k == 5) begin c.Csignout = 1; c.ADD = 1; c.BRANCH = 1; c.Zlowin = 1; end
      if (k == 6) begin c.Zlowout = 1; c.PCin = cf; end
    end else if (k == 3) begin
      case (op)
        OP_JR:   begin c.Gra = 1; c.Rout = 1; c.PCin = 1; end
        OP_IN:   begin c.InPortout = 1; c.Gra = 1; c.Rin = 1; end
        OP_OUT:  begin c.Gra = 1; c.Rout = 1; c.Out_Portin = 1; end
        OP_MFHI: begin c.HIout = 1; c.Gra = 1; c.Rin = 1; end
        OP_MFLO: begin c.LOout = 1; c.Gra = 1; c.Rin = 1; end
        default: ;
      endcase
    end
    return c;
  endfunction

  task automatic do_reset();
    clear = 1'b0;
    stop  = 1'b0;
    #1;
    check("rst_strobes", 64'(obs), 64'd0);
    check("rst_run", 64'(run), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    mcount = 0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock); #1;
    check("reset_s_strobes", 64'(obs), 64'd0);
    check("reset_s_run", 64'(run), 64'd0);
  endtask

  // Runs one instruction; stop pulses at step stop_at, or holds on the last step if stop_last.
  task automatic do_instr(input logic [31:0] ir, input logic cf6, input int stop_at,
                          input bit stop_last, input int abort_k);
    logic [4:0] op;
    int lat;
    op  = ir[31:27];
    lat = ref_lat(op);
    for (int k = 0; k < lat; k++) begin
      @(negedge clock);
      if (k == 0) IR = ir;
      CONFF = (k == 6) ? cf6 : 1'($urandom);
      stop  = (k == stop_at) || (stop_last && k == lat - 1);
      #1;
      check($sformatf("op%02b_t%0d_strobes", op, k), 64'(obs), 64'(ref_step(op, k, CONFF)));
      check($sformatf("op%02b_t%0d_run", op, k), 64'(run), 64'd1);
      check($sformatf("op%02b_t%0d_count", op, k), 64'(instr_count), 64'(mcount % (1 << CW)));
      if (k == abort_k) return;
    end
    mcount++;
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); #1;
      check("halt_strobes", 64'(obs), 64'd0);
      check("halt_run", 64'(run), 64'd0);
      check("halt_count", 64'(instr_count), 64'(mcount % (1 << CW)));
    end
  endtask

  logic [4:0] legal_ops [16] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
                                 OP_ORI, OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP};

  initial begin
    logic [4:0] op;
    int st_at;
    #3;
    do_reset();
    do_instr(32'h00900054, 1'b0, -1, 1'b0, 4);
    do_reset();
    do_instr(32'h19890000, 1'b0, -1, 1'b0, -1);
    do_instr(32'h00900054, 1'b0, -1, 1'b0, -1);
    do_instr(32'h98800004, 1'b1, -1, 1'b0, -1);
    do_instr(32'h98800004, 1'b0, -1, 1'b0, -1);
    do_instr(32'hF8000000, 1'b0, -1, 1'b0, -1);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 5'($urandom);
        if (op == OP_HALT) op = OP_NOP;
      end else begin
        op = legal_ops[$urandom_range(0, 15)];
      end
      st_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ref_lat(op) - 2)) : -1;
      do_instr({op, 27'($urandom)}, 1'($urandom), st_at, 1'b0, -1);
    end
    do_instr(32'h19890000, 1'b0, 4, 1'b0, -1);
    do_instr(32'h19890000, 1'b0, 4, 1'b1, -1);
    halt_hold(5);
    do_reset();
    do_instr(32'hD8000000, 1'b0, -1, 1'b0, -1);
    halt_hold(100);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
